dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory interface. Serves one load or store at a time through a valid/ready request and response handshake.
- Wait states are programmable, so the MEM stage can be verified against a memory that takes more than one cycle and must stall the pipeline.
- Holds word-addressed storage internally. Byte-lane write enables support SB/SH/SW.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_if.sv | 14 +
 rtl/dmem_array.sv | 21 ++
 rtl/dmem_responder.sv | 72 +++++++
 tb/tb_dmem_responder.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and alignment check for the data-memory responder
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  function automatic logic misaligned(input logic we, input logic [1:0] a, input logic [BE_W-1:0] be);
    return (be == 4'b1111 && a != 2'b00) || ((be == 4'b0011 || be == 4'b1100) && a[0]) || (we && be == 4'b0000);
  endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: valid/ready request and response channels between pipeline and data memory
interface dmem_if;
  import dmem_pkg::*;
  logic req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0] req_be;
  logic resp_valid, resp_ready, resp_err;
  logic [WORD_W-1:0] resp_rdata;
  modport master (output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
                  input req_ready, resp_valid, resp_rdata, resp_err);
  modport slave (input req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
                 output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with byte-lane writes and registered read
module dmem_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          din,
  output logic [31:0]          dout
);
  logic [31:0] mem [2**ADDR_BITS];
  always_ff @(posedge clk)
    if (en) begin
      if (we)
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      dout <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time data-memory responder with programmable wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, err_q;
  logic [ADDR_BITS-1:0] idx_q, src_idx;
  logic [WORD_W-1:0] wdata_q, src_wdata, ram_dout;
  logic [BE_W-1:0] be_q, src_be;
  logic idle, accept, src_we, src_err, enter_resp, resp_valid;
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:ADDR_BITS+2];
  // In IDLE the RAM is fed straight from the bus so zero wait states still access on the accept edge
  always_comb begin
    idle = state_q == IDLE;
    accept = idle && bus.req_valid;
    src_we = idle ? bus.req_we : we_q;
    src_idx = idle ? bus.req_addr[ADDR_BITS+1:2] : idx_q;
    src_wdata = idle ? bus.req_wdata : wdata_q;
    src_be = idle ? bus.req_be : be_q;
    src_err = idle ? misaligned(bus.req_we, bus.req_addr[1:0], bus.req_be) : err_q;
    state_d = idle ? (accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
            : state_q == WAIT ? (cnt_q == 4'd1 ? RESP : WAIT)
            : (bus.resp_ready ? IDLE : RESP);
    cnt_d = accept ? 4'(WAIT_CYCLES) : (state_q == WAIT ? cnt_q - 4'd1 : cnt_q);
    enter_resp = state_d == RESP && state_q != RESP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else if (accept) begin
      we_q <= src_we;
      err_q <= src_err;
      idx_q <= src_idx;
      wdata_q <= src_wdata;
      be_q <= src_be;
    end
  dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk  (clk),
    .en   (enter_resp && !src_err),
    .we   (src_we),
    .be   (src_be),
    .addr (src_idx),
    .din  (src_wdata),
    .dout (ram_dout)
  );
  assign resp_valid = state_q == RESP;
  assign bus.req_ready = idle;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_err = resp_valid && err_q;
  assign bus.resp_rdata = (resp_valid && !we_q && !err_q) ? ram_dout : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for a 2-wait-state and a zero-wait-state responder
module tb_dmem_responder;
  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  logic clk = 0, rst = 0;
  logic [1:0] rv = '0, rw = '0, rr = '0;
  logic [31:0] ra [2], rd [2];
  logic [3:0] rb [2];
  logic [1:0] qready, svalid, serr;
  logic [31:0] sdata [2];
  exp_t sb [2][$];
  int nchk = 0, nfail = 0;
  always #5 clk = ~clk;
  dmem_if b0 ();
  dmem_if b1 ();
  assign b0.req_valid = rv[0];
  assign b0.req_we = rw[0];
  assign b0.req_addr = ra[0];
  assign b0.req_wdata = rd[0];
  assign b0.req_be = rb[0];
  assign b0.resp_ready = rr[0];
  assign b1.req_valid = rv[1];
  assign b1.req_we = rw[1];
  assign b1.req_addr = ra[1];
  assign b1.req_wdata = rd[1];
  assign b1.req_be = rb[1];
  assign b1.resp_ready = rr[1];
  assign qready = {b1.req_ready, b0.req_ready};
  assign svalid = {b1.resp_valid, b0.resp_valid};
  assign serr = {b1.resp_err, b0.resp_err};
  assign sdata[0] = b0.resp_rdata;
  assign sdata[1] = b1.resp_rdata;
  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : mon
    always @(negedge clk)
      if (svalid[g] && rr[g]) begin
        exp_t e;
        if (sb[g].size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_resp unit %0d: got rdata %h, expected no response", g, sdata[g]);
        end else begin
          e = sb[g].pop_front();
          chk("resp_rdata", sdata[g], e.rdata);
          chk("resp_err", 32'(serr[g]), 32'(e.err));
        end
      end
  end
  task automatic issue(input int u, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    rw[u] = we; ra[u] = a; rd[u] = d; rb[u] = be; rv[u] = 1'b1;
    @(negedge clk);
    while (!qready[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_budget", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 rv[u] = 1'b0;
  endtask
  task automatic finish_resp(input int u, input int stall, input logic [31:0] er);
    int lat = 1;
    while (!svalid[u] && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, u == 0 ? 3 : 1);
    for (int i = 0; i < stall; i++) begin
      chk("hold_valid", 32'(svalid[u]), 32'd1);
      chk("hold_rdata", sdata[u], er);
      chk("hold_req_ready", 32'(qready[u]), 32'd0);
      @(posedge clk);
      #1;
    end
    rr[u] = 1'b1;
    @(posedge clk);
    #1 rr[u] = 1'b0;
    chk("req_ready_after_resp", 32'(qready[u]), 32'd1);
    chk("valid_dropped", 32'(svalid[u]), 32'd0);
  endtask
  task automatic xfer(input int u, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] er, input logic ee, input int stall);
    issue(u, we, a, d, be);
    sb[u].push_back('{er, ee});
    finish_resp(u, stall, er);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rd[i] = '0; rb[i] = '0;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 32'(qready[i]), 32'd1);
      chk("rst_resp_valid", 32'(svalid[i]), 32'd0);
      chk("rst_resp_rdata", sdata[i], 32'd0);
      chk("rst_resp_err", 32'(serr[i]), 32'd0);
    end
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 0);
    xfer(0, 0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 0, 0);
    xfer(0, 1, 32'h10, 32'h00AB0000, 4'b0100, 32'h0, 0, 0);
    xfer(0, 0, 32'h10, 32'h0, 4'b1111, 32'hDEABBEEF, 0, 0);
    xfer(0, 1, 32'h12, 32'h12345678, 4'b1111, 32'h0, 1, 0);
    xfer(0, 1, 32'h11, 32'h5555AAAA, 4'b0011, 32'h0, 1, 0);
    xfer(0, 1, 32'h10, 32'h77777777, 4'b0000, 32'h0, 1, 0);
    xfer(0, 0, 32'h13, 32'h0, 4'b1111, 32'h0, 1, 0);
    xfer(0, 0, 32'h10, 32'h0, 4'b1111, 32'hDEABBEEF, 0, 5);
    xfer(0, 1, 32'h12, 32'hCAFE0000, 4'b1100, 32'h0, 0, 0);
    xfer(0, 0, 32'h10, 32'h0, 4'b1111, 32'hCAFEBEEF, 0, 0);
    xfer(0, 1, 32'h20, 32'h11111111, 4'b1111, 32'h0, 0, 0);
    issue(0, 1, 32'h20, 32'hBADBAD00, 4'b1111);
    chk("wait_req_ready", 32'(qready[0]), 32'd0);
    chk("wait_resp_valid", 32'(svalid[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req_ready", 32'(qready[0]), 32'd1);
    chk("async_rst_resp_valid", 32'(svalid[0]), 32'd0);
    chk("async_rst_resp_rdata", sdata[0], 32'd0);
    chk("async_rst_resp_err", 32'(serr[0]), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    xfer(0, 0, 32'h20, 32'h0, 4'b1111, 32'h11111111, 0, 0);
    xfer(1, 1, 32'h1000, 32'hA5A55A5A, 4'b1111, 32'h0, 0, 0);
    xfer(1, 0, 32'h0, 32'h0, 4'b1111, 32'hA5A55A5A, 0, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("sb0_drained", sb[0].size(), 32'd0);
    chk("sb1_drained", sb[1].size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
